// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle, byte-addressed, little-endian data memory that
// acts as the target end of the CPU load/store port. It serves one request at
// a time: accept, wait LATENCY cycles, commit the access, hold the response.
// Optional build macro: DMEM_ALIGN_CHECK_EN (reject accesses where addr is
// not a multiple of size). Without it, misaligned accesses are served bytewise.
module dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [3:0]  req_size,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [3:0]  size_q, size_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] addrLow;
    logic          sizeOk;
    logic          rangeErr;
    logic          misaligned;
    logic          accessErr;
    logic          commitWrite;
    logic [63:0]   loadData;

    assign addrLow = addr_q[AW-1:0];

    assign sizeOk = (size_q == 4'd1) || (size_q == 4'd2) ||
                    (size_q == 4'd4) || (size_q == 4'd8);

    // Any address bit above the storage range is out of range outright; the
    // remaining low part is checked with one extra bit so addr+size can't wrap.
    assign rangeErr = (addr_q[63:AW] != '0) ||
                      (({1'b0, addrLow} + (AW+1)'(size_q)) > (AW+1)'(DEPTH));

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned = (addr_q[3:0] & (size_q - 4'd1)) != 4'd0;
`else
    assign misaligned = 1'b0;
`endif

    assign accessErr = !sizeOk || rangeErr || misaligned;

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // Assemble the little-endian load word; bytes beyond the size stay zero.
    always_comb begin
        loadData = '0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < size_q) begin
                loadData[8*i +: 8] = mem[addrLow + AW'(i)];
            end
        end
    end

    // Next-state logic: capture on accept, count down in BUSY, resolve the
    // access on the last BUSY cycle, then hold the response until taken.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        size_d      = size_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        commitWrite = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    size_d  = req_size;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d     = RESP;
                    err_d       = accessErr;
                    rdata_d     = (accessErr || write_q) ? 64'd0 : loadData;
                    commitWrite = write_q && !accessErr;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                    rdata_d = 64'd0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and response registers; reset abandons any pending work.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
            size_q  <= 4'd0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage array is never cleared; a store is dropped if reset hits its edge.
    always_ff @(posedge clk) begin
        if (!reset && commitWrite) begin
            for (int i = 0; i < 8; i++) begin
                if (4'(i) < size_q) begin
                    mem[addrLow + AW'(i)] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: drives directed and random load/store traffic into
// dmem_responder and compares each response with a byte-array model of memory.
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 3;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [3:0]  req_size;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    int compareCount = 0;
    int failCount    = 0;

    logic [7:0] modelMem [DEPTH];

    dmem_responder #(
        .DEPTH  (DEPTH),
        .LATENCY(LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_size  (req_size),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net in case something stalls outside the bounded waits.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compareCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference behaviour: error rules from plain address arithmetic, then a
    // bytewise little-endian read or write of the model array.
    function automatic void modelAccess(input bit wr, input logic [63:0] a, input logic [63:0] wd,
                                        input logic [3:0] sz, output logic e, output logic [63:0] rd);
        logic [64:0] endAddr;
        endAddr = {1'b0, a} + 65'(sz);
        e = !(sz == 4'd1 || sz == 4'd2 || sz == 4'd4 || sz == 4'd8) || (endAddr > 65'(DEPTH));
`ifdef DMEM_ALIGN_CHECK_EN
        if (!e && (a % 64'(sz)) != 64'd0) e = 1'b1;
`endif
        rd = 64'd0;
        if (!e) begin
            for (int i = 0; i < int'(sz); i++) begin
                if (wr) modelMem[int'(a) + i] = wd[8*i +: 8];
                else    rd[8*i +: 8] = modelMem[int'(a) + i];
            end
        end
    endfunction

    task automatic pulseReset();
        reset     = 1'b1;
        req_valid = 1'b0;
        resp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One full transaction, entered and left at a negedge with the DUT idle.
    // Junk requests are held on the bus while the DUT is busy to show they are
    // ignored; the response is held for 'hold' cycles before being taken.
    task automatic applyStimulus(input string tag, input bit wr, input logic [63:0] a,
                                 input logic [63:0] wd, input logic [3:0] sz, input int hold,
                                 output logic [63:0] gotData, output logic gotErr);
        logic        expErr;
        logic [63:0] expData;
        int          waited;
        modelAccess(wr, a, wd, sz, expErr, expData);
        checkOutput({tag, "_idle_ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = wd;
        req_size  = sz;
        @(posedge clk);
        @(negedge clk);
        req_write = 1'($urandom);
        req_addr  = 64'($urandom_range(0, DEPTH - 1));
        req_wdata = {$urandom, $urandom};
        req_size  = 4'($urandom_range(1, 8));
        waited = 0;
        while (!resp_valid && waited < 40) begin
            checkOutput({tag, "_busy_ready"}, 64'(req_ready), 64'd0);
            @(posedge clk);
            @(negedge clk);
            waited++;
        end
        checkOutput({tag, "_latency"}, 64'(waited), 64'(LAT));
        if (!resp_valid) begin
            gotData = 64'd0;
            gotErr  = 1'b0;
            pulseReset();
            return;
        end
        gotData = resp_rdata;
        gotErr  = resp_err;
        checkOutput({tag, "_err"}, 64'(resp_err), 64'(expErr));
        checkOutput({tag, "_rdata"}, resp_rdata, expData);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput({tag, "_hold_valid"}, 64'(resp_valid), 64'd1);
            checkOutput({tag, "_hold_ready"}, 64'(req_ready), 64'd0);
            checkOutput({tag, "_hold_rdata"}, resp_rdata, expData);
            checkOutput({tag, "_hold_err"}, 64'(resp_err), 64'(expErr));
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        checkOutput({tag, "_done_valid"}, 64'(resp_valid), 64'd0);
        checkOutput({tag, "_done_ready"}, 64'(req_ready), 64'd1);
        checkOutput({tag, "_done_rdata"}, resp_rdata, 64'd0);
        checkOutput({tag, "_done_err"}, 64'(resp_err), 64'd0);
    endtask

    // Main sequence: reset, clear memory through the port, directed cases,
    // then randomized traffic.
    initial begin
        logic [63:0] d;
        logic        e;
        logic [3:0]  sizeTable [10];
        logic [3:0]  sz;
        logic [63:0] a;
        int          mode;

        sizeTable = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd0};

        reset      = 1'b1;
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_addr   = 64'd0;
        req_wdata  = 64'hDEAD_BEEF_DEAD_BEEF;
        req_size   = 4'd8;
        resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_req_ready", 64'(req_ready), 64'd1);
        checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("rst_rdata", resp_rdata, 64'd0);
        checkOutput("rst_err", 64'(resp_err), 64'd0);
        reset     = 1'b0;
        req_valid = 1'b0;

        for (int i = 0; i < DEPTH / 8; i++) begin
            applyStimulus("clear", 1'b1, 64'(i * 8), 64'd0, 4'd8, 0, d, e);
        end

        applyStimulus("st8", 1'b1, 64'h10, 64'h0123456789ABCDEF, 4'd8, 0, d, e);
        applyStimulus("ld8", 1'b0, 64'h10, 64'd0, 4'd8, 0, d, e);
        checkOutput("plan_ld8", d, 64'h0123456789ABCDEF);
        applyStimulus("ld2_12", 1'b0, 64'h12, 64'd0, 4'd2, 0, d, e);
        checkOutput("plan_ld2_12", d, 64'h0000_0000_0000_89AB);
        applyStimulus("ld2_14", 1'b0, 64'h14, 64'd0, 4'd2, 0, d, e);
        checkOutput("plan_ld2_14", d, 64'h0000_0000_0000_4567);
        applyStimulus("st1", 1'b1, 64'h10, 64'h0000_0000_0000_00FF, 4'd1, 0, d, e);
        applyStimulus("ld8b", 1'b0, 64'h10, 64'd0, 4'd8, 0, d, e);
        checkOutput("plan_ld8b", d, 64'h0123456789ABCDFF);

        applyStimulus("hold5", 1'b0, 64'h10, 64'd0, 4'd8, 5, d, e);

        applyStimulus("ld_top", 1'b0, 64'(DEPTH - 4), 64'd0, 4'd8, 0, d, e);
        checkOutput("plan_top_err", 64'(e), 64'd1);
        applyStimulus("sz3", 1'b0, 64'h10, 64'd0, 4'd3, 0, d, e);
        checkOutput("plan_sz3_err", 64'(e), 64'd1);
        applyStimulus("st_hi", 1'b1, 64'h1_0000_0000, 64'h5555_6666_7777_8888, 4'd8, 0, d, e);
        checkOutput("plan_hi_err", 64'(e), 64'd1);
        applyStimulus("ld_hi_chk", 1'b0, 64'h0, 64'd0, 4'd8, 0, d, e);
        checkOutput("plan_hi_unchanged", d, 64'd0);

        applyStimulus("st_mis", 1'b1, 64'h21, 64'hAABBCCDD, 4'd4, 0, d, e);
`ifdef DMEM_ALIGN_CHECK_EN
        checkOutput("plan_mis_err", 64'(e), 64'd1);
        applyStimulus("ld_mis", 1'b0, 64'h21, 64'd0, 4'd1, 0, d, e);
        checkOutput("plan_mis_data", d, 64'd0);
`else
        checkOutput("plan_mis_err", 64'(e), 64'd0);
        applyStimulus("ld_mis", 1'b0, 64'h21, 64'd0, 4'd4, 0, d, e);
        checkOutput("plan_mis_data", d, 64'hAABBCCDD);
`endif

        applyStimulus("st40", 1'b1, 64'h40, 64'h1122334455667788, 4'd8, 0, d, e);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 64'h40;
        req_wdata = 64'hFFFF_0000_FFFF_0000;
        req_size  = 4'd8;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("busyrst_req_ready", 64'(req_ready), 64'd1);
        checkOutput("busyrst_resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("busyrst_rdata", resp_rdata, 64'd0);
        checkOutput("busyrst_err", 64'(resp_err), 64'd0);
        applyStimulus("ld40", 1'b0, 64'h40, 64'd0, 4'd8, 0, d, e);
        checkOutput("plan_busyrst_mem", d, 64'h1122334455667788);

        for (int n = 0; n < 250; n++) begin
            sz   = sizeTable[$urandom_range(0, 9)];
            mode = $urandom_range(0, 9);
            if (mode == 0)      a = {$urandom, $urandom};
            else if (mode == 1) a = 64'(DEPTH - 8 + $urandom_range(0, 7));
            else if (mode < 6)  a = 64'($urandom_range(0, 127));
            else                a = 64'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 1) == 1 && sz != 4'd0) a = a & ~(64'(sz) - 64'd1);
            applyStimulus("rand", 1'($urandom), a, {$urandom, $urandom}, sz,
                          $urandom_range(0, 3), d, e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
